// File: rtl/salu_pkg.sv
// salu_pkg: shared definitions for the scalar-ALU writeback slice.
//   - ALU control-word format codes (one-hot, control[31:24])
//   - SOPP branch opcodes and s_and_saveexec_b64 opcode (control[23:0])
//   - writeback state encoding and captured-instruction bundle
//   - branch resolution helper
package salu_pkg;

  localparam logic [7:0] SALU_SOPP = 8'h01;
  localparam logic [7:0] SALU_SOP1 = 8'h02;
  localparam logic [7:0] SALU_SOPC = 8'h04;
  localparam logic [7:0] SALU_SOP2 = 8'h08;
  localparam logic [7:0] SALU_SOPK = 8'h10;

  localparam logic [23:0] S_BRANCH           = 24'h000002;
  localparam logic [23:0] S_CBRANCH_SCC0     = 24'h000004;
  localparam logic [23:0] S_CBRANCH_SCC1     = 24'h000005;
  localparam logic [23:0] S_CBRANCH_VCCZ     = 24'h000006;
  localparam logic [23:0] S_CBRANCH_EXECZ    = 24'h000008;
  localparam logic [23:0] S_AND_SAVEEXEC_B64 = 24'h000024;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } salu_wb_state_e;

  // Width-independent part of the instruction presented by the ALU.
  typedef struct packed {
    logic [7:0]  fmt;
    logic [23:0] opcode;
    logic        b64;
    logic [31:0] pc;
    logic        sgpr_dst_en;
    logic        exec_dst_en;
    logic        scc_wr;
    logic [63:0] exec;
    logic [63:0] vcc;
    logic [63:0] alu_out;
    logic        alu_scc;
  } salu_capture_t;

  // Returns {branch_valid, branch_taken}; scc is the value before this
  // instruction's own SCC update.
  function automatic logic [1:0] salu_branch_resolve(input salu_capture_t c,
                                                     input logic scc);
    logic [1:0] r;
    r = 2'b00;
    if (c.fmt == SALU_SOPP) begin
      case (c.opcode)
        S_BRANCH:        r = 2'b11;
        S_CBRANCH_SCC0:  r = {1'b1, ~scc};
        S_CBRANCH_SCC1:  r = {1'b1, scc};
        S_CBRANCH_VCCZ:  r = {1'b1, (c.vcc == 64'd0)};
        S_CBRANCH_EXECZ: r = {1'b1, (c.exec == 64'd0)};
        default:         r = 2'b00;
      endcase
    end else begin
      r = 2'b00;
    end
    return r;
  endfunction

endpackage

// File: rtl/salu_scc_file.sv
// salu_scc_file: per-wavefront SCC bits, NUM_WF x 1.
//   clk, rst            clock, synchronous active-high reset (clears all bits)
//   wr_en/wr_wfid/wr_data  write port; out-of-range ids are ignored
//   rd_wfid -> rd_data  external read, bypassed from a same-cycle write
//   iss_wfid -> iss_data  raw (un-bypassed) read for branch resolution
// Out-of-range reads return 0.
module salu_scc_file
  import salu_pkg::*;
#(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WFID_W-1:0] wr_wfid,
  input  logic              wr_data,
  input  logic [WFID_W-1:0] rd_wfid,
  output logic              rd_data,
  input  logic [WFID_W-1:0] iss_wfid,
  output logic              iss_data
);

  logic [NUM_WF-1:0] scc_r;
  logic              wr_ok_s;

  function automatic logic in_range(input logic [WFID_W-1:0] id);
    return (32'(id) < 32'(NUM_WF));
  endfunction

  assign wr_ok_s = wr_en & in_range(wr_wfid);

  // SCC storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      scc_r <= '0;
    end else if (wr_ok_s) begin
      scc_r[wr_wfid] <= wr_data;
    end else begin
      scc_r <= scc_r;
    end
  end

  // External read with same-cycle write forwarding.
  always_comb begin
    rd_data = 1'b0;
    if (!in_range(rd_wfid)) begin
      rd_data = 1'b0;
    end else if (wr_ok_s && (wr_wfid == rd_wfid)) begin
      rd_data = wr_data;
    end else begin
      rd_data = scc_r[rd_wfid];
    end
  end

  // Issue-side read: pre-update value, so a branch sees SCC as it was.
  always_comb begin
    iss_data = 1'b0;
    if (in_range(iss_wfid)) begin
      iss_data = scc_r[iss_wfid];
    end else begin
      iss_data = 1'b0;
    end
  end

endmodule

// File: rtl/salu_writeback.sv
// salu_writeback: one-entry stage after the scalar ALU.
// Captures the ALU result on the accepting edge, then for one cycle drives
// SGPR/EXEC write strobes and SOPP branch resolution; retirement is held on
// retire_valid/retire_wfid until retire_ready.
// Ports: clk, rst (sync, active high); in_* ALU result + issue tag with
// in_valid/in_ready; sgpr_wr_*, exec_wr_*, wr_wfid register writes;
// branch_* branch outcome; retire_* handshake to the wavefront controller;
// scc_rd_wfid/scc_rd_data SCC read port for the operand/branch path.
// Optional: define SALU_WB_PERF_CNT_EN to add perf_retired, perf_br_taken
// and perf_stall_cycles (32-bit wrapping counters).
module salu_writeback
  import salu_pkg::*;
#(
  parameter int NUM_WF      = 40,
  parameter int WFID_W      = 6,
  parameter int SGPR_ADDR_W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_control,
  input  logic                   in_b64_op,
  input  logic [WFID_W-1:0]      in_wfid,
  input  logic [31:0]            in_pc,
  input  logic                   in_sgpr_dst_en,
  input  logic [SGPR_ADDR_W-1:0] in_sgpr_dst_addr,
  input  logic                   in_exec_dst_en,
  input  logic                   in_scc_wr,
  input  logic [63:0]            in_exec,
  input  logic [63:0]            in_vcc,
  input  logic [63:0]            alu_out,
  input  logic                   alu_scc_val,
  output logic                   sgpr_wr_en,
  output logic [SGPR_ADDR_W-1:0] sgpr_wr_addr,
  output logic [63:0]            sgpr_wr_data,
  output logic [1:0]             sgpr_wr_mask,
  output logic                   exec_wr_en,
  output logic [63:0]            exec_wr_data,
  output logic [WFID_W-1:0]      wr_wfid,
  output logic                   branch_valid,
  output logic                   branch_taken,
  output logic [31:0]            branch_target,
  output logic                   retire_valid,
  output logic [WFID_W-1:0]      retire_wfid,
  input  logic                   retire_ready,
  input  logic [WFID_W-1:0]      scc_rd_wfid,
  output logic                   scc_rd_data
`ifdef SALU_WB_PERF_CNT_EN
 ,output logic [31:0]            perf_retired,
  output logic [31:0]            perf_br_taken,
  output logic [31:0]            perf_stall_cycles
`endif
);

  salu_wb_state_e state_r;
  salu_capture_t  cap_s;
  logic           accept_s;
  logic           scc_wr_s;
  logic           scc_old_s;
  logic [1:0]     br_s;
  logic           save_exec_s;
  logic [63:0]    sgpr_src_s;
  logic [63:0]    sgpr_data_s;
  logic [1:0]     sgpr_mask_s;
  logic [31:0]    br_target_s;

  // A full stage can still accept when the occupant retires this cycle.
  assign in_ready = (state_r == WB_EMPTY) | retire_ready;
  assign accept_s = in_valid & in_ready;
  assign scc_wr_s = accept_s & cap_s.scc_wr;

  // Bundle the incoming instruction.
  always_comb begin
    cap_s             = '0;
    cap_s.fmt         = in_control[31:24];
    cap_s.opcode      = in_control[23:0];
    cap_s.b64         = in_b64_op;
    cap_s.pc          = in_pc;
    cap_s.sgpr_dst_en = in_sgpr_dst_en;
    cap_s.exec_dst_en = in_exec_dst_en;
    cap_s.scc_wr      = in_scc_wr;
    cap_s.exec        = in_exec;
    cap_s.vcc         = in_vcc;
    cap_s.alu_out     = alu_out;
    cap_s.alu_scc     = alu_scc_val;
  end

  salu_scc_file #(
    .NUM_WF (NUM_WF),
    .WFID_W (WFID_W)
  ) u_scc_file (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (scc_wr_s),
    .wr_wfid  (in_wfid),
    .wr_data  (cap_s.alu_scc),
    .rd_wfid  (scc_rd_wfid),
    .rd_data  (scc_rd_data),
    .iss_wfid (in_wfid),
    .iss_data (scc_old_s)
  );

  // Write data, mask and branch outcome derived from the incoming instruction.
  always_comb begin
    save_exec_s = (cap_s.fmt == SALU_SOP1) && (cap_s.opcode == S_AND_SAVEEXEC_B64);
    // saveexec stores the old EXEC to the SGPR and the ALU result to EXEC
    sgpr_src_s  = save_exec_s ? cap_s.exec : cap_s.alu_out;
    if (cap_s.b64) begin
      sgpr_data_s = sgpr_src_s;
      sgpr_mask_s = 2'b11;
    end else begin
      sgpr_data_s = {32'd0, sgpr_src_s[31:0]};
      sgpr_mask_s = 2'b01;
    end
    br_s        = salu_branch_resolve(cap_s, scc_old_s);
    br_target_s = br_s[0] ? cap_s.alu_out[31:0] : (cap_s.pc + 32'd4);
  end

  // Occupancy FSM with registered strobes and retirement outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= WB_EMPTY;
      sgpr_wr_en    <= 1'b0;
      sgpr_wr_addr  <= '0;
      sgpr_wr_data  <= 64'd0;
      sgpr_wr_mask  <= 2'b00;
      exec_wr_en    <= 1'b0;
      exec_wr_data  <= 64'd0;
      wr_wfid       <= '0;
      branch_valid  <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= 32'd0;
      retire_valid  <= 1'b0;
      retire_wfid   <= '0;
    end else begin
      // strobes are single-cycle regardless of retirement back-pressure
      sgpr_wr_en   <= 1'b0;
      exec_wr_en   <= 1'b0;
      branch_valid <= 1'b0;
      case (state_r)
        WB_EMPTY, WB_FULL: begin
          if (accept_s) begin
            state_r       <= WB_FULL;
            retire_valid  <= 1'b1;
            retire_wfid   <= in_wfid;
            wr_wfid       <= in_wfid;
            sgpr_wr_en    <= cap_s.sgpr_dst_en;
            sgpr_wr_addr  <= in_sgpr_dst_addr;
            sgpr_wr_data  <= sgpr_data_s;
            sgpr_wr_mask  <= sgpr_mask_s;
            exec_wr_en    <= cap_s.exec_dst_en;
            exec_wr_data  <= cap_s.alu_out;
            branch_valid  <= br_s[1];
            branch_taken  <= br_s[0];
            branch_target <= br_target_s;
          end else if ((state_r == WB_FULL) && retire_ready) begin
            state_r      <= WB_EMPTY;
            retire_valid <= 1'b0;
          end else begin
            state_r      <= state_r;
          end
        end
        default: begin
          state_r      <= WB_EMPTY;
          retire_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SALU_WB_PERF_CNT_EN
  // Retirement, taken-branch and stall event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired      <= 32'd0;
      perf_br_taken     <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (retire_valid && retire_ready) begin
        perf_retired <= perf_retired + 32'd1;
      end else begin
        perf_retired <= perf_retired;
      end
      if (branch_valid && branch_taken) begin
        perf_br_taken <= perf_br_taken + 32'd1;
      end else begin
        perf_br_taken <= perf_br_taken;
      end
      if ((state_r == WB_FULL) && !retire_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end else begin
        perf_stall_cycles <= perf_stall_cycles;
      end
    end
  end
`endif

endmodule

// File: doc/salu_writeback.md
Name: salu_writeback

Overview:
- Pipeline stage directly downstream of the scalar ALU. Captures the combinational ALU result (64-bit out, scc_val) with the issue tag.
- Produces SGPR/EXEC write strobes and resolves SOPP branches against a per-wavefront SCC file. It also reports retirement to the wavefront controller over a valid/ready handshake.
- The SCC file read port feeds back to the operand/branch path upstream.

Parameters:
- NUM_WF, 40, number of wavefronts; sizes the SCC file.
- WFID_W, 6, wavefront id width.
- SGPR_ADDR_W, 9, SGPR destination address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept; in_valid is ignored when low
- in_control  in  32  ALU control word; [31:24] format one-hot (SOPP 01, SOP1 02, SOPC 04, SOP2 08, SOPK 10), [23:0] opcode
- in_b64_op  in  1  64-bit result
- in_wfid  in  WFID_W  wavefront id
- in_pc  in  32  instruction PC
- in_sgpr_dst_en  in  1  result goes to SGPR
- in_sgpr_dst_addr  in  SGPR_ADDR_W  SGPR destination
- in_exec_dst_en  in  1  result goes to EXEC
- in_scc_wr  in  1  instruction updates SCC
- in_exec  in  64  wavefront EXEC at issue
- in_vcc  in  64  wavefront VCC at issue
- alu_out  in  64  ALU result
- alu_scc_val  in  1  ALU SCC result
- sgpr_wr_en  out  1  one-cycle SGPR write strobe
- sgpr_wr_addr  out  SGPR_ADDR_W
- sgpr_wr_data  out  64
- sgpr_wr_mask  out  2  [0] low dword, [1] high dword
- exec_wr_en  out  1  one-cycle EXEC write strobe
- exec_wr_data  out  64
- wr_wfid  out  WFID_W  wavefront for all writes
- branch_valid  out  1  one-cycle; a SOPP branch resolved
- branch_taken  out  1
- branch_target  out  32  next PC (taken target or pc+4)
- retire_valid  out  1  instruction complete
- retire_wfid  out  WFID_W
- retire_ready  in  1  wavefront controller accepts retirement
- scc_rd_wfid  in  WFID_W  SCC file read address
- scc_rd_data  out  1  SCC of scc_rd_wfid (combinational, write-bypassed)

Behaviour:
- Reset: all outputs 0, in_ready 1, state EMPTY, all SCC entries 0.
- States:
  - EMPTY: accept on in_valid → FULL.
  - FULL: holds the captured instruction.
  - FULL & retire_ready: with in_valid → FULL (back-to-back); otherwise → EMPTY.
- in_ready = (state==EMPTY) | retire_ready.
- Latency: capture on the accepting edge. Strobes (sgpr_wr_en, exec_wr_en, branch_valid) and retire_valid rise the next cycle.
- Strobes last exactly one cycle even while retirement stalls. retire_valid, retire_wfid and wr_wfid hold until retire_ready.
- SGPR write:
  - sgpr_wr_en = captured in_sgpr_dst_en.
  - Mask is 11 if b64, else 01. High data is zeroed when 32-bit.
- s_and_saveexec_b64 (SOP1 0x24): sgpr_wr_data = captured in_exec; exec_wr_data = alu_out. All other EXEC writes: exec_wr_data = alu_out.
- SCC: on accept with in_scc_wr, scc[in_wfid] <= alu_scc_val at the capture edge.
- scc_rd_data bypasses when scc_rd_wfid==in_wfid & in_valid & in_ready & in_scc_wr.
- Branch resolution uses SCC as read before this instruction's update. SOPP opcodes:
  - 02: always taken.
  - 04: taken if scc==0.
  - 05: taken if scc==1.
  - 06: taken if captured vcc==0.
  - 08: taken if captured exec==0.
  - Other SOPP opcodes: branch_valid 0.
- branch_target = taken ? alu_out[31:0] : in_pc+4, with 32-bit wrap.
- in_wfid ≥ NUM_WF: SCC write suppressed; scc_rd_data 0 for out-of-range reads.
- rst mid-operation: pending instruction dropped, no strobes, SCC cleared.

Optional Feature:
- Macro: SALU_WB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_retired, perf_br_taken and perf_stall_cycles, each 32 bits, wrapping.
  - perf_stall_cycles counts FULL & !retire_ready cycles.
  - All three are cleared by rst.
- When undefined: ports and counters are absent.

Decomposition:
- Package salu_pkg:
  - Format codes SALU_SOPP/SOP1/SOPC/SOP2/SOPK.
  - Opcode constants S_BRANCH, S_CBRANCH_SCC0/SCC1/VCCZ/EXECZ, S_AND_SAVEEXEC_B64.
  - Captured-instruction struct typedef.
- Sub-module salu_scc_file: NUM_WF×1 register file, one write and one bypassed read port.

Test Plan:
- 1. s_add_u32, wfid 3, dst s5, alu_out 0x1_0000_0002, scc_wr, retire_ready=1 → next cycle sgpr_wr_en=1, addr 5, data 0x0000_0000_0000_0002, mask 01; retire_valid for wfid 3; scc[3]=1.
- 2. s_cbranch_scc1 on wfid 3 after test 1, pc 0x100, alu_out 0x140 → branch_valid=1, taken=1, target 0x140. Repeat with scc[3]=0 → taken=0, target 0x104.
- 3. s_and_saveexec_b64, in_exec=0xFFFF_0000_FFFF_0000, alu_out=0x0000_0000_FFFF_0000 → sgpr data=0xFFFF_0000_FFFF_0000 mask 11; exec_wr_data=0x0000_0000_FFFF_0000.
- 4. retire_ready=0 for 3 cycles → strobes high 1 cycle only; retire_valid held 3+ cycles; in_ready=0; a second in_valid is not captured until release, then follows back-to-back.
- 5. Same-cycle SCC write on wfid 7 with scc_rd_wfid=7, alu_scc_val=1 → scc_rd_data=1 in that cycle.
- 6. rst asserted while FULL with retire stalled → next cycle retire_valid=0, in_ready=1, scc_rd_data=0 for every wfid; with SALU_WB_PERF_CNT_EN defined, counters read 0.
